alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one ALU instance between NUM_REQ requesters.
- Accepts operations through per-requester valid/ready handshakes and grants them round-robin.
- Registers the operands, drives the ALU for exactly one cycle, then returns the result on a single tagged response channel.
- Sits between the issue logic of several execution clients and the shared ALU datapath.

Parameters:
WIDTH, 32, operand/result width in bits.
FUNCTION, 6, funct field width; matches the ALU funct input.
NUM_REQ, 2, number of requesters (>=2).
ID_W, $clog2(NUM_REQ), width of the response requester ID.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  NUM_REQ  per-requester operation valid.
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
req_a  input  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
req_b  input  NUM_REQ*WIDTH  packed operand B.
req_funct  input  NUM_REQ*FUNCTION  packed funct codes.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response accept.
rsp_data  output  WIDTH  result.
rsp_id  output  ID_W  index of the requester that issued the operation.
rsp_err  output  1  illegal funct (>7).
alu_a  output  WIDTH  to ALU A.
alu_b  output  WIDTH  to ALU B.
alu_funct  output  FUNCTION  to ALU funct.
alu_enable  output  1  to ALU enable.
alu_out  input  WIDTH  from ALU out.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - alu_enable=0, alu_a=0, alu_b=0, alu_funct=0.
- Reset mid-operation discards the in-flight operation; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; all other bits are 0.
  - On the edge: capture a/b/funct/id of the grant into registers, and set rr_ptr=(grant+1) mod NUM_REQ.
  - Legal funct (0..7): go to EXEC.
  - Illegal funct (>7): go directly to RESP with rsp_data=0 and rsp_err=1. The ALU is never enabled.
  - No valid requests: stay in IDLE with req_ready=0.
- EXEC (exactly one cycle):
  - alu_enable=1; alu_a/b/funct driven from the operand registers.
  - On the edge: rsp_data<=alu_out, rsp_err<=0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data/id/err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE, rsp_valid<=0.
  - No new request is accepted in RESP; req_ready=0.
- alu_enable=0 in IDLE and RESP. alu_a/b/funct keep their last values; they are registered and never X.
- Timing:
  - Accept at edge N gives rsp_valid from cycle N+1 (illegal funct) or N+2 (legal).
  - Minimum spacing between accepts is 3 cycles with rsp_ready tied high.
- Requesters must hold req_valid and their operand slices until req_ready. Dropping req_valid before grant is legal; that request is simply not granted.
- Simultaneous requests: the rr_ptr order decides. No requester waits more than NUM_REQ grants.
- rsp_ready asserted without rsp_valid is ignored.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum {IDLE, EXEC, RESP}.
  - funct constants: FN_ZERO=0, FN_ADD=1, FN_SUB=2, FN_AND=3, FN_OR=4, FN_SUB_ALT=5, FN_SLT=6, FN_SLL=7, FN_MAX=7.
- Sub-module rr_picker: combinational, NUM_REQ-parameterised.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_valid.
- The ALU itself stays external and is connected by the integrator.

Test Plan:
- Single op: requester 0 sends a=5, b=3, funct=1 at cycle 0, rsp_ready=1 -> alu_enable high only in cycle 1; rsp_valid in cycle 2 with rsp_data=8, rsp_id=0, rsp_err=0.
- Contention: both valid every cycle, req0 funct=2 (10-4), req1 funct=3 (0xF0&0x3C) -> grants alternate 0,1,0,1; responses 6 (id 0), 0x30 (id 1), repeating. req_ready is never two-hot.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/id stable, req_ready=0 throughout; the response retires on the first rsp_ready=1 cycle, and the next grant follows one cycle later.
- Illegal funct: req1 funct=9 -> alu_enable never asserts; rsp_valid the cycle after accept with rsp_data=0, rsp_err=1, rsp_id=1.
- SLT/SLL: a=2, b=7, funct=6 -> rsp_data=1. a=1, b=0x24, funct=7 -> rsp_data=0x10 (shift by b[4:0]=4).
- Reset mid-EXEC: rst high for 1 cycle during EXEC -> next cycle all outputs at reset values, no rsp_valid; a fresh request afterwards is granted starting from requester 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared FSM state type and ALU funct encodings for the ALU arbiter.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam int unsigned FN_ZERO    = 0;
    localparam int unsigned FN_ADD     = 1;
    localparam int unsigned FN_SUB     = 2;
    localparam int unsigned FN_AND     = 3;
    localparam int unsigned FN_OR      = 4;
    localparam int unsigned FN_SUB_ALT = 5;
    localparam int unsigned FN_SLT     = 6;
    localparam int unsigned FN_SLL     = 7;
    localparam int unsigned FN_MAX     = 7;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!any_valid && req[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NUM_REQ requesters,
// with a single tagged response channel.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FUNCTION = 6,
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    input  logic [NUM_REQ*FUNCTION-1:0]  req_funct,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         rsp_err,
    output logic [WIDTH-1:0]             alu_a,
    output logic [WIDTH-1:0]             alu_b,
    output logic [FUNCTION-1:0]          alu_funct,
    output logic                         alu_enable,
    input  logic [WIDTH-1:0]             alu_out
);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     next_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any_valid;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;
    logic [FUNCTION-1:0] sel_funct;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign sel_a     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_b     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_funct = req_funct[int'(grant_idx)*FUNCTION +: FUNCTION];
    assign next_ptr  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    // The accept is combinational so a grant costs no extra cycle in IDLE.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every register updates from pre-edge values.
        if (rst) begin
            // NOTE: all state here is plain registers (no memories), so everything is reset and never X.
            state      <= IDLE;
            rr_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            alu_enable <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_funct  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_a     <= sel_a;
                        alu_b     <= sel_b;
                        alu_funct <= sel_funct;
                        rsp_id    <= grant_idx;
                        rr_ptr    <= next_ptr;
                        if (sel_funct > FUNCTION'(FN_MAX)) begin
                            // Illegal funct bypasses the ALU entirely.
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_enable <= 1'b1;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    alu_enable <= 1'b0;
                    rsp_data   <= alu_out;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model, directed pins, random traffic.
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    localparam int WIDTH    = 32;
    localparam int FUNCTION = 6;
    localparam int NUM_REQ  = 2;
    localparam int ID_W     = 1;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*WIDTH-1:0]    req_a = '0;
    logic [NUM_REQ*WIDTH-1:0]    req_b = '0;
    logic [NUM_REQ*FUNCTION-1:0] req_funct = '0;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b1;
    logic [WIDTH-1:0]            rsp_data;
    logic [ID_W-1:0]             rsp_id;
    logic                        rsp_err;
    logic [WIDTH-1:0]            alu_a;
    logic [WIDTH-1:0]            alu_b;
    logic [FUNCTION-1:0]         alu_funct;
    logic                        alu_enable;
    logic [WIDTH-1:0]            alu_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .WIDTH    (WIDTH),
        .FUNCTION (FUNCTION),
        .NUM_REQ  (NUM_REQ),
        .ID_W     (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_funct  (req_funct),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct  (alu_funct),
        .alu_enable (alu_enable),
        .alu_out    (alu_out)
    );

    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [FUNCTION-1:0] f);
        int unsigned fi;
        fi = f;
        case (fi)
            FN_ZERO:            return '0;
            FN_ADD:             return a + b;
            FN_SUB, FN_SUB_ALT: return a - b;
            FN_AND:             return a & b;
            FN_OR:              return a | b;
            FN_SLT:             return ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            FN_SLL:             return a << b[4:0];
            default:            return '0;
        endcase
    endfunction

    // External ALU stand-in; garbage when not enabled so mistimed captures show up.
    assign alu_out = alu_enable ? alu_ref(alu_a, alu_b, alu_funct) : 32'hDEAD_BEEF;

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding op with its expected timeline.
    int                  cyc = 0;
    bit                  m_busy = 1'b0;
    bit                  m_rst_pend = 1'b1;
    bit                  m_err = 1'b0;
    int                  m_ptr = 0;
    int                  m_en_cyc = -1;
    int                  m_rsp_cyc = 0;
    int                  m_id = 0;
    logic [WIDTH-1:0]    m_a = '0;
    logic [WIDTH-1:0]    m_b = '0;
    logic [WIDTH-1:0]    m_data = '0;
    logic [FUNCTION-1:0] m_f = '0;
    logic [NUM_REQ-1:0]  acc_seen = '0;
    logic                prev_rspv = 1'b0;

    int               grant_log[$];
    int               acc_log[$];
    int               en_log[$];
    int               rspv_log[$];
    int               ret_log[$];
    int               log_id[$];
    logic [WIDTH-1:0] log_data[$];
    bit               log_err[$];

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        int g;
        g = pick(req_valid, m_ptr);
        exp_ready = '0;
        if (!m_busy && !rst && g >= 0) exp_ready[g] = 1'b1;

        if (m_rst_pend) begin
            check("reset rsp_data", rsp_data, 0);
            check("reset rsp_id", rsp_id, 0);
            check("reset rsp_err", rsp_err, 0);
            check("reset alu_a", alu_a, 0);
            check("reset alu_b", alu_b, 0);
            check("reset alu_funct", alu_funct, 0);
        end
        check("req_ready", req_ready, exp_ready);
        check("req_ready onehot", $countones(req_ready) <= 1, 1);
        check("rsp_valid", rsp_valid, m_busy && cyc >= m_rsp_cyc);
        check("alu_enable", alu_enable, m_busy && cyc == m_en_cyc);
        if (m_busy && cyc >= m_rsp_cyc) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
            check("rsp_err", rsp_err, m_err);
        end
        if (m_busy && cyc == m_en_cyc) begin
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_funct", alu_funct, m_f);
        end

        acc_seen = req_valid & req_ready & {NUM_REQ{!rst}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_seen[i]) begin
                grant_log.push_back(i);
                acc_log.push_back(cyc);
            end
        end
        if (alu_enable) en_log.push_back(cyc);
        if (rsp_valid && !prev_rspv) rspv_log.push_back(cyc);
        prev_rspv = rsp_valid;
        if (rsp_valid && rsp_ready && !rst) begin
            log_data.push_back(rsp_data);
            log_id.push_back(int'(rsp_id));
            log_err.push_back(rsp_err);
            ret_log.push_back(cyc);
        end

        m_rst_pend = rst;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy    = 1'b1;
                m_id      = g;
                m_a       = req_a[g*WIDTH +: WIDTH];
                m_b       = req_b[g*WIDTH +: WIDTH];
                m_f       = req_funct[g*FUNCTION +: FUNCTION];
                m_err     = (m_f > 7);
                m_data    = m_err ? '0 : alu_ref(m_a, m_b, m_f);
                m_en_cyc  = m_err ? -1 : cyc + 1;
                m_rsp_cyc = m_err ? cyc + 1 : cyc + 2;
                m_ptr     = (g + 1) % NUM_REQ;
            end
        end else if (cyc >= m_rsp_cyc && rsp_ready) begin
            m_busy = 1'b0;
        end
        cyc++;
    end

    bit keep_valid = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = req_valid & ~acc_seen;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [FUNCTION-1:0] f);
        req_a[i*WIDTH +: WIDTH]           = a;
        req_b[i*WIDTH +: WIDTH]           = b;
        req_funct[i*FUNCTION +: FUNCTION] = f;
        req_valid[i]                      = 1'b1;
    endtask

    task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [FUNCTION-1:0] f);
        int n;
        set_op(i, a, b, f);
        n = 0;
        while (req_valid[i] && n < 50) begin
            tick();
            n++;
        end
        if (req_valid[i]) begin
            check("accept timeout", 0, 1);
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        grant_log.delete(); acc_log.delete(); en_log.delete(); rspv_log.delete();
        ret_log.delete(); log_id.delete(); log_data.delete(); log_err.delete();
    endtask

    task automatic check_rsp(input int k, input logic [WIDTH-1:0] data, input int id, input bit err);
        if (log_data.size() > k) begin
            check($sformatf("rsp%0d data", k), log_data[k], data);
            check($sformatf("rsp%0d id", k), log_id[k], id);
            check($sformatf("rsp%0d err", k), log_err[k], err);
        end else begin
            check($sformatf("rsp%0d missing", k), log_data.size(), k + 1);
        end
    endtask

    task automatic wait_grants(input int n);
        int t;
        t = 0;
        while (grant_log.size() < n && t < 60) begin
            tick();
            t++;
        end
        if (grant_log.size() < n) check("grant timeout", grant_log.size(), n);
    endtask

    initial begin
        // Single op 5+3.
        do_reset();
        clear_logs();
        issue(0, 5, 3, 1);
        repeat (4) tick();
        check_rsp(0, 8, 0, 0);
        check("single enable count", en_log.size(), 1);
        if (en_log.size() > 0 && acc_log.size() > 0 && rspv_log.size() > 0) begin
            check("single enable latency", en_log[0] - acc_log[0], 1);
            check("single rsp latency", rspv_log[0] - acc_log[0], 2);
        end

        // Contention: both requesters valid continuously.
        do_reset();
        clear_logs();
        set_op(0, 10, 4, 2);
        set_op(1, 32'hF0, 32'h3C, 3);
        keep_valid = 1'b1;
        wait_grants(4);
        keep_valid = 1'b0;
        req_valid = '0;
        repeat (4) tick();
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check($sformatf("contention grant%0d", k), grant_log[k], k % 2);
        check_rsp(0, 6, 0, 0);
        check_rsp(1, 32'h30, 1, 0);
        check_rsp(2, 6, 0, 0);
        check_rsp(3, 32'h30, 1, 0);
        if (acc_log.size() > 1) check("accept spacing", acc_log[1] - acc_log[0], 3);

        // Backpressure: hold the response for 5 cycles.
        do_reset();
        clear_logs();
        rsp_ready = 1'b0;
        set_op(0, 7, 8, 1);
        set_op(1, 3, 4, 4);
        for (int t = 0; t < 20 && !rsp_valid; t++) tick();
        for (int k = 0; k < 5; k++) begin
            check("hold rsp_valid", rsp_valid, 1);
            check("hold rsp_data", rsp_data, 15);
            check("hold rsp_id", rsp_id, 0);
            check("hold req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_grants(2);
        repeat (5) tick();
        check_rsp(0, 15, 0, 0);
        check_rsp(1, 7, 1, 0);
        if (grant_log.size() > 1) check("bp second grant", grant_log[1], 1);
        if (acc_log.size() > 1 && ret_log.size() > 0)
            check("grant after retire", acc_log[1] - ret_log[0], 1);

        // Illegal funct never touches the ALU.
        do_reset();
        clear_logs();
        issue(1, 1, 2, 9);
        repeat (4) tick();
        check_rsp(0, 0, 1, 1);
        check("illegal enable count", en_log.size(), 0);
        if (rspv_log.size() > 0 && acc_log.size() > 0)
            check("illegal rsp latency", rspv_log[0] - acc_log[0], 1);

        // SLT, SLL, signed SLT, SUB_ALT.
        clear_logs();
        issue(0, 2, 7, 6);
        repeat (4) tick();
        issue(1, 1, 32'h24, 7);
        repeat (4) tick();
        issue(0, 32'hFFFF_FFFF, 1, 6);
        repeat (4) tick();
        issue(1, 9, 4, 5);
        repeat (4) tick();
        check_rsp(0, 1, 0, 0);
        check_rsp(1, 32'h10, 1, 0);
        check_rsp(2, 1, 0, 0);
        check_rsp(3, 5, 1, 0);

        // Reset during EXEC discards the op and restarts the pointer.
        do_reset();
        clear_logs();
        issue(0, 5, 6, 1);
        check("exec enable", alu_enable, 1);
        rst = 1'b1;
        set_op(0, 1, 2, 1);
        set_op(1, 4, 4, 1);
        tick();
        rst = 1'b0;
        check("post-reset rsp_valid", rsp_valid, 0);
        check("post-reset alu_enable", alu_enable, 0);
        check("post-reset rsp_data", rsp_data, 0);
        clear_logs();
        wait_grants(1);
        req_valid = '0;
        repeat (5) tick();
        if (grant_log.size() > 0) check("post-reset first grant", grant_log[0], 0);
        check("post-reset rsp count", log_data.size(), 1);
        check_rsp(0, 3, 0, 0);

        // Random traffic with random backpressure and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 249) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_op(i,
                               $urandom_range(0, 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 40)),
                               $urandom_range(0, 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 40)),
                               ($urandom_range(0, 7) == 0) ? FUNCTION'($urandom_range(8, 63))
                                                           : FUNCTION'($urandom_range(0, 7)));
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
